// File: rtl/config_arb_pkg.sv
// Shared types and helpers for the configuration-memory write arbiter.
package config_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_ACK   = 2'b10
  } state_e;

  localparam int unsigned CFG_DATA_W = 35;

  // Bits needed to index 'value' entries; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/config_write_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_picker
  import config_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               any,
  output logic [PTR_W-1:0]   sel
);

  int unsigned idx;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    any = |req;
    sel = '0;
    idx = 0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      idx = (32'(ptr) + i - 1) % NUM_REQ;
      if (req[idx]) sel = PTR_W'(idx);
    end
  end

endmodule

// File: rtl/config_write_arbiter.sv
// Round-robin arbiter sharing the configuration memory write port among
// several requesters, with bounded back-pressure wait and ack/err pulses.
module config_write_arbiter
  import config_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned DATA_W  = CFG_DATA_W,
  parameter  int unsigned TIMEOUT = 15,
  localparam int unsigned ID_W    = clog2(NUM_REQ),
  localparam int unsigned CNT_W   = clog2(TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      req_err,
  output logic [DATA_W-1:0]         mem_data,
  output logic                      mem_we,
  input  logic                      mem_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic [1:0]                dbg_state
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [CNT_W-1:0]     busy_cnt_q, busy_cnt_d;
  logic [DATA_W-1:0]    mem_data_q, mem_data_d;
  logic                 mem_we_q, mem_we_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic                 req_err_q, req_err_d;
  logic                 post_ack_q, post_ack_d;

  logic [NUM_REQ-1:0]   req_mask;
  logic [NUM_REQ-1:0]   req_masked;
  logic                 pick_any;
  logic [ID_W-1:0]      pick_sel;

  // The just-served requester is hidden for one idle cycle so it can drop valid.
  always_comb begin
    req_mask = '0;
    if (state_q == S_IDLE && post_ack_q) req_mask[grant_id_q] = 1'b1;
    req_masked = req_valid & ~req_mask;
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req (req_masked),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .sel (pick_sel)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    busy_cnt_d = busy_cnt_q;
    mem_data_d = mem_data_q;
    mem_we_d   = mem_we_q;
    req_ack_d  = '0;
    req_err_d  = 1'b0;
    post_ack_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_sel;
          mem_data_d = req_data[pick_sel*DATA_W +: DATA_W];
          mem_we_d   = 1'b1;
          busy_cnt_d = '0;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!mem_busy) begin
          mem_we_d              = 1'b0;
          req_ack_d[grant_id_q] = 1'b1;
          state_d               = S_ACK;
        end else if (busy_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_we_d              = 1'b0;
          req_ack_d[grant_id_q] = 1'b1;
          req_err_d             = 1'b1;
          state_d               = S_ACK;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        rr_ptr_d   = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        post_ack_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        mem_we_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      busy_cnt_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      req_ack_q  <= '0;
      req_err_q  <= 1'b0;
      post_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      busy_cnt_q <= busy_cnt_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      req_ack_q  <= req_ack_d;
      req_err_q  <= req_err_d;
      post_ack_q <= post_ack_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign req_err   = req_err_q;
  assign mem_data  = mem_data_q;
  assign mem_we    = mem_we_q;
  assign grant_id  = grant_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_config_write_arbiter.sv
// Directed bench for config_write_arbiter: vector table plus hand sequences.
module tb_config_write_arbiter;

  logic         clk = 1'b0;
  logic         arst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [139:0] req_data = '0;
  logic [3:0]   req_ack;
  logic         req_err;
  logic [34:0]  mem_data;
  logic         mem_we;
  logic         mem_busy = 1'b0;
  logic [1:0]   grant_id;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int acc_cnt  = 0;

  config_write_arbiter #(.NUM_REQ(4), .DATA_W(35), .TIMEOUT(15)) dut (
    .clk       (clk),
    .arst      (arst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .req_err   (req_err),
    .mem_data  (mem_data),
    .mem_we    (mem_we),
    .mem_busy  (mem_busy),
    .grant_id  (grant_id),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Count writes the memory actually accepts.
  always @(posedge clk) if (!arst && mem_we && !mem_busy) acc_cnt <= acc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [34:0] data_of(input int i);
    case (i)
      0:       return 35'h0_AAAA_0000;
      1:       return 35'h1_2345_6789;
      2:       return 35'h7_0F0F_0F0F;
      default: return 35'h2_DEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait for a grant, hold mem_busy for busy_n cycles, then check the ack cycle.
  task automatic do_txn(input string tag, input logic [1:0] exp_g, input int busy_n,
                        input logic exp_err, input int exp_we, input bit drop);
    int          waitc = 0;
    int          wec   = 0;
    int          acc0;
    bit          stable = 1'b1;
    logic [34:0] d0;
    logic [3:0]  exp_ack;
    acc0 = acc_cnt;
    mem_busy = 1'b0;
    do begin
      @(negedge clk);
      waitc++;
    end while (!mem_we && waitc < 10);
    check({tag, "_grant_seen"}, 64'(mem_we), 64'd1);
    if (!mem_we) return;
    check({tag, "_grant_id"}, 64'(grant_id), 64'(exp_g));
    check({tag, "_mem_data"}, 64'(mem_data), 64'(data_of(int'(exp_g))));
    d0 = mem_data;
    while (mem_we && wec < 40) begin
      wec++;
      if (mem_data !== d0) stable = 1'b0;
      mem_busy = (wec <= busy_n);
      @(negedge clk);
    end
    mem_busy = 1'b0;
    exp_ack = 4'b0001 << exp_g;
    check({tag, "_we_cycles"}, 64'(wec), 64'(exp_we));
    check({tag, "_data_stable"}, 64'(stable), 64'd1);
    check({tag, "_ack"}, 64'(req_ack), 64'(exp_ack));
    check({tag, "_err"}, 64'(req_err), 64'(exp_err));
    check({tag, "_accepted"}, 64'(acc_cnt - acc0), exp_err ? 64'd0 : 64'd1);
    if (drop) req_valid[exp_g] = 1'b0;
  endtask

  typedef struct {
    logic [3:0] valid;
    int         busy_n;
    logic [1:0] g;
    logic       err;
    int         we;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Pointer trace from 2: g0->1, g3->0, g2->3, g1->2, g2->3, g3->0, g0->1.
    vecs[0] = '{4'b0011,  0, 2'd0, 1'b0,  1};
    vecs[1] = '{4'b1001,  5, 2'd3, 1'b0,  6};
    vecs[2] = '{4'b0100, 99, 2'd2, 1'b1, 15};
    vecs[3] = '{4'b0110, 14, 2'd1, 1'b0, 15};
    vecs[4] = '{4'b1100,  0, 2'd2, 1'b0,  1};
    vecs[5] = '{4'b1100,  0, 2'd3, 1'b0,  1};
    vecs[6] = '{4'b0001, 13, 2'd0, 1'b0, 14};

    for (int i = 0; i < 4; i++) req_data[i*35 +: 35] = data_of(i);

    @(negedge clk);
    @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_ack", 64'(req_ack), 64'd0);
    check("rst_err", 64'(req_err), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_data", 64'(mem_data), 64'd0);
    arst = 1'b0;
    @(negedge clk);

    // Single request from requester 1.
    req_valid = 4'b0010;
    do_txn("single", 2'd1, 0, 1'b0, 1, 1'b1);
    req_valid = '0;
    @(negedge clk);
    check("single_rr_ptr", 64'(dut.rr_ptr_q), 64'd2);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      req_valid = vecs[i].valid;
      do_txn($sformatf("vec%0d", i), vecs[i].g, vecs[i].busy_n, vecs[i].err, vecs[i].we, 1'b1);
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
    end
    check("table_rr_ptr", 64'(dut.rr_ptr_q), 64'd1);

    // Fairness from a fresh reset: all valid, each drops on its ack.
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    req_valid = 4'b1111;
    for (int g = 0; g < 4; g++) do_txn($sformatf("fair%0d", g), 2'(g), 0, 1'b0, 1, 1'b1);
    check("fair_valid_left", 64'(req_valid), 64'd0);
    @(negedge clk);
    check("fair_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
    @(negedge clk);

    // Sticky requester 2 alone: no regrant in the masked cycle, regrant after.
    req_valid = 4'b0100;
    do_txn("sticky", 2'd2, 0, 1'b0, 1, 1'b0);
    @(negedge clk);
    check("sticky_masked_we", 64'(mem_we), 64'd0);
    @(negedge clk);
    check("sticky_idle2_we", 64'(mem_we), 64'd0);
    check("sticky_idle2_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    check("sticky_regrant_we", 64'(mem_we), 64'd1);
    check("sticky_regrant_id", 64'(grant_id), 64'd2);
    @(negedge clk);
    check("sticky_regrant_ack", 64'(req_ack), 64'b0100);
    // Sticky 2 with requester 0 present: 0 wins straight out of the masked cycle.
    req_valid = 4'b0101;
    @(negedge clk);
    check("other_masked_we", 64'(mem_we), 64'd0);
    @(negedge clk);
    check("other_grant_we", 64'(mem_we), 64'd1);
    check("other_grant_id", 64'(grant_id), 64'd0);
    @(negedge clk);
    check("other_ack", 64'(req_ack), 64'b0001);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset during WRITE with rr_ptr at 1.
    req_valid = 4'b0100;
    mem_busy  = 1'b1;
    for (int w = 0; w < 10 && !mem_we; w++) @(negedge clk);
    check("midrst_write_seen", 64'(mem_we), 64'd1);
    @(negedge clk);
    #2 arst = 1'b1;
    #1;
    check("midrst_we", 64'(mem_we), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    check("midrst_ack", 64'(req_ack), 64'd0);
    req_valid = '0;
    mem_busy  = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check("postrst_ack", 64'(req_ack), 64'd0);
    check("postrst_rr_ptr", 64'(dut.rr_ptr_q), 64'd0);
    req_valid = 4'b1001;
    do_txn("postrst", 2'd0, 0, 1'b0, 1, 1'b1);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
